// File: rtl/refill_arbiter_pkg.sv
// rtl/refill_arbiter_pkg.sv - shared encodings for the refill arbiter
// Purpose: FSM state encoding, line owner encoding and the default line size.
// Ports: none (package).
package refill_arbiter_pkg;

  localparam int LINE_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/refill_arbiter_rr_arb2.sv
// rtl/refill_arbiter_rr_arb2.sv - two-way round-robin picker for ICache/DCache
// Purpose: picks I or D; on a tie the side that did not win last time wins.
// Ports: clk, rst (sync active-high), en (grant is taken this cycle),
//        req_i, req_d (requests), grant (OWN_NONE/OWN_I/OWN_D, combinational).
module rr_arb2
  import refill_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   req_i,
  input  logic   req_d,
  output owner_t grant
);

  owner_t last;

  always_comb begin
    grant = OWN_NONE;
    if (req_i && req_d) begin
      grant = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (req_i) begin
      grant = OWN_I;
    end else if (req_d) begin
      grant = OWN_D;
    end
  end

  // Starts at I so that D wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= OWN_I;
    end else if (en && (grant != OWN_NONE)) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - shares the memory word port between ICache and DCache line transfers
// Purpose: grants one cache a whole line (LINE_WORDS word transactions), then pulses its done.
// Ports: clk, rst (sync active-high);
//        ICache: i_req, i_addr -> i_rvalid, i_done;
//        DCache: d_req, d_we, d_addr, d_wdata -> d_wnext, d_rvalid, d_done;
//        shared read return: rd_data, rd_idx;
//        memory: mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack.
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_rvalid,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_wnext,
  output logic             d_rvalid,
  output logic             d_done,
  output logic [31:0]      rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
);

  localparam int               BASE_W   = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_WORDS - 1);

  state_t            state;
  state_t            state_nx;
  owner_t            owner;
  owner_t            grant;
  logic [IDX_W-1:0]  cnt;
  logic [BASE_W-1:0] line_base;
  logic              we_lat;
  logic              busy;
  logic              is_write;
  logic              unused_addr_bits;

  // Word-offset bits of the line addresses are replaced by the counter.
  assign unused_addr_bits = ^{i_addr[IDX_W+1:0], d_addr[IDX_W+1:0]};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_IDLE),
    .req_i (i_req),
    .req_d (d_req),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (grant != OWN_NONE) state_nx = ST_BUSY;
      ST_BUSY: if (mem_ack && (cnt == CNT_LAST)) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_BUSY);
    is_write  = (owner == OWN_D) && we_lat;
    mem_req   = busy;
    mem_we    = busy && is_write;
    mem_addr  = busy ? {line_base, cnt, 2'b00} : 32'd0;
    mem_wdata = (busy && is_write) ? d_wdata : 32'd0;
    // Write side is told combinationally so it can present the next word without a bubble.
    d_wnext   = busy && is_write && mem_ack;
    i_done    = (state == ST_DONE) && (owner == OWN_I);
    d_done    = (state == ST_DONE) && (owner == OWN_D);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_NONE;
      line_base <= '0;
      we_lat    <= 1'b0;
      cnt       <= '0;
      rd_data   <= 32'd0;
      rd_idx    <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != OWN_NONE) begin
            owner     <= grant;
            line_base <= (grant == OWN_D) ? d_addr[31:IDX_W+2] : i_addr[31:IDX_W+2];
            we_lat    <= (grant == OWN_D) && d_we;
            cnt       <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            // Power-of-two line: the increment wraps to 0 after the last word.
            cnt <= cnt + 1'b1;
            if (!is_write) begin
              rd_data  <= mem_rdata;
              rd_idx   <= cnt;
              i_rvalid <= (owner == OWN_I);
              d_rvalid <= (owner == OWN_D);
            end
          end
        end
        ST_DONE: owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// tb/tb_refill_arbiter.sv - self-checking bench for refill_arbiter
module tb_refill_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_rvalid, i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_wnext, d_rvalid, d_done;
  logic [31:0] rd_data;
  logic [2:0]  rd_idx;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  refill_arbiter #(.LINE_WORDS(LW), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wnext(d_wnext), .d_rvalid(d_rvalid), .d_done(d_done),
    .rd_data(rd_data), .rd_idx(rd_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  // Reference model: line in flight described by owner, base and words moved so far.
  bit          m_busy = 0, m_done = 0, m_we = 0, m_rvi = 0, m_rvd = 0;
  int          m_owner = 0, m_last = 1, m_word = 0, m_ridx = 0;
  logic [31:0] m_base = 32'd0, m_rdata = 32'd0;

  initial forever begin
    @(posedge clk);
    m_rvi = 0;
    m_rvd = 0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_owner = 0; m_last = 1; m_word = 0;
      m_we = 0; m_base = 32'd0; m_rdata = 32'd0; m_ridx = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        if (!(m_owner == 2 && m_we)) begin
          m_rdata = mem_rdata;
          m_ridx  = m_word;
          if (m_owner == 1) m_rvi = 1; else m_rvd = 1;
        end
        m_word++;
        if (m_word == LW) begin
          m_busy = 0; m_done = 1; m_word = 0;
        end
      end
    end else if (m_done) begin
      m_done = 0;
      m_owner = 0;
    end else if (i_req || d_req) begin
      if (i_req && d_req) m_owner = (m_last == 1) ? 2 : 1;
      else m_owner = i_req ? 1 : 2;
      m_last = m_owner;
      m_base = ((m_owner == 1) ? i_addr : d_addr) & ~32'h1F;
      m_we   = (m_owner == 2) && d_we;
      m_busy = 1;
      m_word = 0;
    end
  end

  // Monitor plus per-cycle comparison against the model.
  int          cyc = 0, wnext_cnt = 0, req_cyc_cnt = 0;
  bit          i_done_seen = 0, d_done_seen = 0, wnext_seen = 0, prev_req = 0;
  logic [31:0] ack_addr_q[$], ack_wdata_q[$], rv_data_q[$];
  int          rv_who_q[$], rv_idx_q[$], done_q[$], done_cyc_q[$], rise_cyc_q[$];

  initial forever begin
    bit e_we;
    @(negedge clk);
    cyc++;
    i_done_seen = i_done;
    d_done_seen = d_done;
    wnext_seen  = d_wnext;
    if (mem_req && mem_ack) begin
      ack_addr_q.push_back(mem_addr);
      ack_wdata_q.push_back(mem_wdata);
    end
    if (i_rvalid) begin rv_who_q.push_back(1); rv_idx_q.push_back(int'(rd_idx)); rv_data_q.push_back(rd_data); end
    if (d_rvalid) begin rv_who_q.push_back(2); rv_idx_q.push_back(int'(rd_idx)); rv_data_q.push_back(rd_data); end
    if (i_done) begin done_q.push_back(1); done_cyc_q.push_back(cyc); end
    if (d_done) begin done_q.push_back(2); done_cyc_q.push_back(cyc); end
    if (mem_req && !prev_req) rise_cyc_q.push_back(cyc);
    prev_req = mem_req;
    if (d_wnext) wnext_cnt++;
    if (mem_req) req_cyc_cnt++;

    e_we = m_busy && (m_owner == 2) && m_we;
    chk("mem_req", mem_req, m_busy);
    chk("mem_addr", mem_addr, m_busy ? m_base + 32'(m_word * 4) : 32'd0);
    chk("mem_we", mem_we, e_we);
    chk("mem_wdata", mem_wdata, e_we ? d_wdata : 32'd0);
    chk("d_wnext", d_wnext, e_we && mem_ack);
    chk("i_done", i_done, m_done && (m_owner == 1));
    chk("d_done", d_done, m_done && (m_owner == 2));
    chk("i_rvalid", i_rvalid, m_rvi);
    chk("d_rvalid", d_rvalid, m_rvd);
    chk("rd_data", rd_data, m_rdata);
    chk("rd_idx", rd_idx, m_ridx);
  end

  // Requesters and memory are driven one step per clock, #1 after the rising edge.
  int          i_lines = 0, d_lines = 0, wcnt = 0;
  int          wait_min = 0, wait_max = 0, wait_cnt = 0, wait_tgt = 0;
  logic [31:0] i_next_addr = 32'd0, d_next_addr = 32'd0, rtag = 32'd0;
  bit          d_next_we = 0, rnd_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      i_next_addr = $urandom;
      d_next_addr = $urandom;
      d_next_we   = 1'($urandom_range(0, 1));
      rtag        = 32'($urandom_range(0, 255)) << 8;
      if (i_req) i_addr = $urandom;
      if (d_req) d_addr = $urandom;
    end
    if (i_req && i_done_seen) begin
      i_lines--;
      if (i_lines == 0) i_req = 1'b0;
    end else if (!i_req && i_lines > 0) begin
      i_req = 1'b1;
      i_addr = i_next_addr;
    end
    if (d_req && d_done_seen) begin
      d_lines--;
      if (d_lines == 0) d_req = 1'b0;
    end else if (!d_req && d_lines > 0) begin
      d_req = 1'b1;
      d_addr = d_next_addr;
      d_we = d_next_we;
    end
    if (rst || d_done_seen) wcnt = 0;
    else if (wnext_seen) wcnt++;
    d_wdata = 32'hD000_0000 + 32'(wcnt);
    if (mem_req) begin
      if (wait_cnt >= wait_tgt) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        wait_tgt = $urandom_range(wait_max, wait_min);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
    mem_rdata = mem_ack ? (32'hA5A5_0000 + rtag + {29'd0, mem_addr[4:2]}) : $urandom;
  endtask

  task automatic set_wait(input int lo, input int hi);
    wait_min = lo;
    wait_max = hi;
    wait_tgt = lo;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_lines = 0; d_lines = 0; i_req = 1'b0; d_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((i_lines > 0 || d_lines > 0 || i_req || d_req || mem_req) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, v0, d0, r0, w0, c0, n;

    do_reset();
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_rd_idx", rd_idx, 3'd0);
    chk("reset_dones", {i_done, d_done, i_rvalid, d_rvalid}, 4'd0);

    // I line read, zero-wait memory.
    set_wait(0, 0);
    a0 = ack_addr_q.size(); v0 = rv_who_q.size(); d0 = done_q.size(); r0 = rise_cyc_q.size();
    i_next_addr = 32'h0000_1234;
    i_lines = 1;
    drain(100);
    chk("t1_words", ack_addr_q.size() - a0, 8);
    for (int k = 0; k < 8; k++) begin
      if (a0 + k < ack_addr_q.size()) chk("t1_addr", ack_addr_q[a0 + k], 32'h1220 + 32'(4 * k));
      if (v0 + k < rv_who_q.size()) begin
        chk("t1_rv_who", rv_who_q[v0 + k], 1);
        chk("t1_rv_idx", rv_idx_q[v0 + k], k);
        chk("t1_rv_data", rv_data_q[v0 + k], 32'hA5A5_0000 + 32'(k));
      end
    end
    chk("t1_rv_count", rv_who_q.size() - v0, 8);
    chk("t1_done_count", done_q.size() - d0, 1);
    if (done_cyc_q.size() > d0 && rise_cyc_q.size() > r0)
      chk("t1_done_latency", done_cyc_q[d0] - rise_cyc_q[r0], 8);

    // D writeback, three wait cycles per word.
    set_wait(3, 3);
    a0 = ack_addr_q.size(); w0 = wnext_cnt; c0 = req_cyc_cnt;
    d_next_addr = 32'h8000_0040; d_next_we = 1'b1;
    d_lines = 1;
    drain(200);
    chk("t2_words", ack_addr_q.size() - a0, 8);
    for (int k = 0; k < 8; k++) begin
      if (a0 + k < ack_addr_q.size()) begin
        chk("t2_addr", ack_addr_q[a0 + k], 32'h8000_0040 + 32'(4 * k));
        chk("t2_wdata", ack_wdata_q[a0 + k], 32'hD000_0000 + 32'(k));
      end
    end
    chk("t2_wnext_count", wnext_cnt - w0, 8);
    chk("t2_req_cycles", req_cyc_cnt - c0, 32);

    // Tie right after reset: D first, then I in the IDLE cycle after d_done.
    do_reset();
    set_wait(0, 1);
    d0 = done_q.size(); r0 = rise_cyc_q.size();
    i_next_addr = 32'h0000_4000; d_next_addr = 32'h0000_6000; d_next_we = 1'b0;
    i_lines = 1; d_lines = 1;
    drain(200);
    chk("t3_done_count", done_q.size() - d0, 2);
    if (done_q.size() >= d0 + 2) begin
      chk("t3_first", done_q[d0], 2);
      chk("t3_second", done_q[d0 + 1], 1);
    end
    if (rise_cyc_q.size() >= r0 + 2 && done_cyc_q.size() > d0)
      chk("t3_i_gap", rise_cyc_q[r0 + 1] - done_cyc_q[d0], 2);

    // D holds d_req over two lines while I waits: D, I, D.
    d0 = done_q.size();
    d_next_addr = 32'h0000_7000; d_next_we = 1'b0;
    d_lines = 2;
    step();
    i_next_addr = 32'h0000_5000;
    i_lines = 1;
    drain(300);
    chk("t4_done_count", done_q.size() - d0, 3);
    if (done_q.size() >= d0 + 3) begin
      chk("t4_order0", done_q[d0], 2);
      chk("t4_order1", done_q[d0 + 1], 1);
      chk("t4_order2", done_q[d0 + 2], 2);
    end

    // Reset in the middle of an I line, then a fresh request.
    set_wait(0, 0);
    a0 = ack_addr_q.size(); d0 = done_q.size();
    i_next_addr = 32'h0000_1234;
    i_lines = 1;
    n = 0;
    while ((ack_addr_q.size() - a0) < 4 && n < 50) begin
      step();
      n++;
    end
    chk("t5_reach_word4", 32'(n < 50), 32'd1);
    rst = 1'b1; i_lines = 0; i_req = 1'b0;
    step();
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_rd_data", rd_data, 32'd0);
    chk("t5_flags", {i_done, i_rvalid, d_done, d_rvalid}, 4'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t5_no_done", done_q.size() - d0, 0);
    a0 = ack_addr_q.size();
    i_lines = 1;
    drain(100);
    chk("t5_restart_words", ack_addr_q.size() - a0, 8);
    if (ack_addr_q.size() > a0) chk("t5_restart_addr", ack_addr_q[a0], 32'h1220);
    chk("t5_restart_done", done_q.size() - d0, 1);

    // D line read with a patterned memory.
    set_wait(0, 2);
    v0 = rv_who_q.size();
    d_next_addr = 32'h0000_0000; d_next_we = 1'b0;
    d_lines = 1;
    drain(200);
    chk("t6_rv_count", rv_who_q.size() - v0, 8);
    for (int k = 0; k < 8; k++) begin
      if (v0 + k < rv_who_q.size()) begin
        chk("t6_rv_who", rv_who_q[v0 + k], 2);
        chk("t6_rv_idx", rv_idx_q[v0 + k], k);
        chk("t6_rv_data", rv_data_q[v0 + k], 32'hA5A5_0000 + 32'(k));
      end
    end

    // Random traffic, random memory latency, occasional reset.
    rnd_mode = 1;
    for (int s = 0; s < 3000; s++) begin
      if ((s % 200) == 0) set_wait(0, $urandom_range(0, 3));
      if (i_lines == 0 && !i_req && $urandom_range(0, 9) == 0) i_lines = $urandom_range(1, 2);
      if (d_lines == 0 && !d_req && $urandom_range(0, 9) == 0) d_lines = $urandom_range(1, 2);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; i_lines = 0; d_lines = 0; i_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
